// File: rtl/inst_fetch.sv
// ============================================================================
// Module   : inst_fetch
// Purpose  : Instruction fetch stage. Owns the PC, issues word reads and
//            buffers returned words in an in-order FIFO for the decoder.
// Revision : 1.0
// ============================================================================
`default_nettype none

module inst_fetch #(
    parameter logic [31:0] cResetPc   = 32'h0000_0000,
    parameter int          cFifoDepth = 4
) (
    input  logic        iClk,
    input  logic        iRst,
    input  logic        iRedirect,
    input  logic [31:0] iRedirectPc,
    output logic        oMemReq,
    output logic [31:0] oMemAddr,
    input  logic        iMemGnt,
    input  logic        iMemRvalid,
    input  logic [31:0] iMemRdata,
    output logic        oValid,
    input  logic        iReady,
    output logic [31:0] oInst,
    output logic [31:0] oPc
);

    localparam int AW = (cFifoDepth > 1) ? $clog2(cFifoDepth) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW:0] c_depth = (CW+1)'(cFifoDepth);

    localparam logic [0:0] S_RUN   = 1'b0;
    localparam logic [0:0] S_DRAIN = 1'b1;

    logic [0:0]    state;
    logic [0:0]    state_nxt;
    logic [31:0]   pc;
    logic [CW-1:0] count;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] outstanding_nxt;
    logic [CW:0]   occupancy;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] tag_wr;
    logic [AW-1:0] tag_rd;
    logic          grant;
    logic          resp;
    logic          push;
    logic          pop;

    logic [31:0] inst_q [cFifoDepth];
    logic [31:0] pc_q   [cFifoDepth];
    logic [31:0] tag_q  [cFifoDepth];

    assign occupancy       = {1'b0, count} + {1'b0, outstanding};
    assign grant           = oMemReq && iMemGnt;
    // A response with nothing outstanding is a protocol error and is ignored.
    assign resp            = iMemRvalid && (outstanding != '0);
    assign push            = resp && (state == S_RUN) && !iRedirect;
    assign pop             = oValid && iReady && !iRedirect;
    assign outstanding_nxt = outstanding + CW'(grant) - CW'(resp);

    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            state <= S_RUN;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (iRedirect) begin
            state_nxt = (outstanding_nxt != '0) ? S_DRAIN : S_RUN;
        end else if ((state == S_DRAIN) && (outstanding_nxt == '0)) begin
            state_nxt = S_RUN;
        end
    end

    always_comb begin
        oMemReq = (state == S_RUN) && !iRedirect && (occupancy < c_depth);
    end

    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            pc          <= cResetPc;
            count       <= '0;
            outstanding <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            tag_wr      <= '0;
            tag_rd      <= '0;
        end else begin
            outstanding <= outstanding_nxt;
            if (grant) begin
                tag_wr <= tag_wr + AW'(1);
            end
            if (resp) begin
                tag_rd <= tag_rd + AW'(1);
            end
            if (iRedirect) begin
                pc     <= iRedirectPc & 32'hFFFF_FFFC;
                count  <= '0;
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (grant) begin
                    pc <= pc + 32'd4;
                end
                count <= count + CW'(push) - CW'(pop);
                if (push) begin
                    wr_ptr <= wr_ptr + AW'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + AW'(1);
                end
            end
        end
    end

    // Storage needs no reset: the head is only exposed while count is non-zero.
    always_ff @(posedge iClk) begin
        if (grant) begin
            tag_q[tag_wr] <= pc;
        end
        if (push) begin
            inst_q[wr_ptr] <= iMemRdata;
            pc_q[wr_ptr]   <= tag_q[tag_rd];
        end
    end

    assign oMemAddr = pc;
    assign oValid   = (count != '0);
    assign oInst    = oValid ? inst_q[rd_ptr] : 32'h0;
    assign oPc      = oValid ? pc_q[rd_ptr]   : 32'h0;

endmodule

`default_nettype wire

// File: tb/tb_inst_fetch.sv
// ============================================================================
// Module   : tb_inst_fetch
// Purpose  : Self-checking bench for inst_fetch against a queue-based model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_inst_fetch;

    localparam logic [31:0] RESET_PC = 32'h0000_0100;
    localparam int          DEPTH    = 4;

    logic        iClk = 1'b0;
    logic        iRst;
    logic        iRedirect;
    logic [31:0] iRedirectPc;
    logic        oMemReq;
    logic [31:0] oMemAddr;
    logic        iMemGnt;
    logic        iMemRvalid;
    logic [31:0] iMemRdata;
    logic        oValid;
    logic        iReady;
    logic [31:0] oInst;
    logic [31:0] oPc;

    inst_fetch #(.cResetPc(RESET_PC), .cFifoDepth(DEPTH)) dut (
        .iClk(iClk), .iRst(iRst),
        .iRedirect(iRedirect), .iRedirectPc(iRedirectPc),
        .oMemReq(oMemReq), .oMemAddr(oMemAddr),
        .iMemGnt(iMemGnt), .iMemRvalid(iMemRvalid), .iMemRdata(iMemRdata),
        .oValid(oValid), .iReady(iReady), .oInst(oInst), .oPc(oPc)
    );

    always #5 iClk = ~iClk;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    int total = 0;
    int bad   = 0;

    // Memory model: in-order responses due at grant cycle + latency.
    mreq_t mq[$];
    int    lat;
    int    last_due;
    int    cyc;

    // Reference model: next fetch PC, in-flight count, buffered PCs, drain flag.
    logic [31:0] m_pc;
    int          m_out;
    logic [31:0] m_fifo[$];
    bit          m_drain;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc     = RESET_PC;
        m_out    = 0;
        m_drain  = 1'b0;
        m_fifo.delete();
        mq.delete();
        last_due = 0;
    endtask

    task automatic step(input bit redir, input logic [31:0] rpc);
        bit          rv;
        bit          e_req;
        bit          e_valid;
        bit          grant;
        bit          resp;
        logic [31:0] e_pc;
        logic [31:0] e_inst;
        logic [31:0] tag;
        int          due;

        rv          = (mq.size() > 0) && (mq[0].due <= cyc);
        iRedirect   = redir;
        iRedirectPc = rpc;
        iMemRvalid  = rv;
        iMemRdata   = rv ? (mq[0].addr + 32'h13) : $urandom;

        e_req   = !m_drain && !redir && ((m_fifo.size() + m_out) < DEPTH);
        e_valid = (m_fifo.size() != 0);
        e_pc    = e_valid ? m_fifo[0] : 32'h0;
        e_inst  = e_valid ? (m_fifo[0] + 32'h13) : 32'h0;

        @(negedge iClk);
        check("mem_req",  {31'b0, oMemReq}, {31'b0, e_req});
        check("mem_addr", oMemAddr, m_pc);
        check("valid",    {31'b0, oValid},  {31'b0, e_valid});
        check("pc",       oPc,   e_pc);
        check("inst",     oInst, e_inst);

        @(posedge iClk);
        grant = e_req && iMemGnt;
        resp  = rv && (m_out > 0);
        tag   = rv ? mq[0].addr : 32'h0;
        if (e_valid && iReady && !redir) void'(m_fifo.pop_front());
        if (resp && !m_drain && !redir) m_fifo.push_back(tag);
        if (rv) void'(mq.pop_front());
        if (grant) begin
            due = cyc + lat;
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            mq.push_back('{addr: m_pc, due: due});
            m_pc  = m_pc + 32'd4;
            m_out = m_out + 1;
        end
        if (resp) m_out = m_out - 1;
        if (redir) begin
            m_fifo.delete();
            m_pc    = rpc & 32'hFFFF_FFFC;
            m_drain = (m_out > 0);
        end else if (m_drain && (m_out == 0)) begin
            m_drain = 1'b0;
        end
        cyc++;
        #1;
    endtask

    initial begin
        iRst        = 1'b0;
        iRedirect   = 1'b0;
        iRedirectPc = 32'h0;
        iMemGnt     = 1'b0;
        iMemRvalid  = 1'b0;
        iMemRdata   = 32'h0;
        iReady      = 1'b0;
        lat         = 1;
        cyc         = 0;
        model_reset();

        // Reset state
        repeat (2) @(posedge iClk);
        #1;
        check("rst_valid", {31'b0, oValid}, 32'h0);
        check("rst_inst",  oInst, 32'h0);
        check("rst_pc",    oPc,   32'h0);
        check("rst_addr",  oMemAddr, RESET_PC);
        iRst = 1'b1;

        // Straight-line fetch, 1-cycle memory
        iMemGnt = 1'b1;
        iReady  = 1'b1;
        repeat (10) step(1'b0, 32'h0);

        // Backpressure until full, then release
        iReady = 1'b0;
        repeat (8) step(1'b0, 32'h0);
        iReady = 1'b1;
        repeat (8) step(1'b0, 32'h0);

        // Redirect from idle-full with unaligned target
        iReady = 1'b0;
        repeat (8) step(1'b0, 32'h0);
        step(1'b1, 32'h0000_2002);
        iReady = 1'b1;
        repeat (6) step(1'b0, 32'h0);

        // Redirect with two requests in flight, 3-cycle memory
        lat = 3;
        for (int i = 0; i < 20 && m_out != 2; i++) step(1'b0, 32'h0);
        check("two_outstanding", m_out, 2);
        step(1'b1, 32'h0000_0400);
        for (int i = 0; i < 20 && m_drain; i++) step(1'b0, 32'h0);
        repeat (8) step(1'b0, 32'h0);

        // Redirect coinciding with a response and a pop
        lat = 1;
        repeat (6) step(1'b0, 32'h0);
        step(1'b1, 32'h0000_0800);
        repeat (6) step(1'b0, 32'h0);

        // PC wrap
        step(1'b1, 32'hFFFF_FFFC);
        repeat (8) step(1'b0, 32'h0);

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            iReady  = ($urandom_range(0, 3) != 0);
            iMemGnt = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 49) == 0) lat = $urandom_range(1, 4);
            if ($urandom_range(0, 24) == 0) step(1'b1, $urandom);
            else                            step(1'b0, 32'h0);
        end

        // Asynchronous reset in the middle of a burst
        lat     = 1;
        iReady  = 1'b1;
        iMemGnt = 1'b1;
        step(1'b1, 32'h0000_3000);
        repeat (6) step(1'b0, 32'h0);
        check("burst_valid", {31'b0, oValid}, 32'h1);
        #2;
        iRst = 1'b0;
        #1;
        check("arst_valid", {31'b0, oValid}, 32'h0);
        check("arst_inst",  oInst, 32'h0);
        check("arst_pc",    oPc,   32'h0);
        check("arst_addr",  oMemAddr, RESET_PC);
        model_reset();
        iMemRvalid = 1'b0;
        @(posedge iClk);
        #1;
        iRst = 1'b1;
        repeat (8) step(1'b0, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
